// File: rtl/lfsr_pkg.sv
// Purpose: shared constants, FSM state type and seed mapping helper for the LFSR word server.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lfsr_pkg;

    localparam int          LFSR_W            = 16;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hA2C1;

    // Feedback taps of the Fibonacci register: s15 ^ s1 ^ s2; s15 is also the serial output.
    localparam int          LFSR_TAP_OUT      = 15;
    localparam int          LFSR_TAP_A        = 1;
    localparam int          LFSR_TAP_B        = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lfsr_sched_state_t;

    // Seed MSB lands in s[0] and seed LSB in s[15], so the register image is
    // the bit-reversed seed. The first serial bit out is therefore seed[0].
    function automatic logic [LFSR_W-1:0] seed_to_state(input logic [LFSR_W-1:0] seed);
        logic [LFSR_W-1:0] s;
        for (int i = 0; i < LFSR_W; i++) begin
            s[i] = seed[LFSR_W-1-i];
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Purpose: 16-bit Fibonacci LFSR (taps s15^s1^s2) with seed load and zero-seed substitution.
// Latency: load/advance take effect on the next clk edge; sout is s[15] combinationally.
// Backpressure: none; the register moves only when adv or load is asserted.
//
// Ports: clk, nrst (async active-low) | adv: step once | load/load_val: reseed
//        (load has priority over adv) | sout: serial output bit s[15].
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              adv,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic              sout
);

    logic [LFSR_W-1:0] s;
    logic              fb;
    logic [LFSR_W-1:0] seed_eff;

    // An all-zero register would lock up forever, so zero is replaced by SEED.
    assign seed_eff = (load_val == '0) ? SEED : load_val;
    assign fb       = s[LFSR_TAP_OUT] ^ s[LFSR_TAP_A] ^ s[LFSR_TAP_B];
    assign sout     = s[LFSR_TAP_OUT];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s <= seed_to_state(SEED);
        end else if (load) begin
            s <= seed_to_state(seed_eff);
        end else if (adv) begin
            // s[0] <= feedback, s[i] <= s[i-1]
            s <= {s[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_rand_sched.sv
// Purpose: round-robin server handing out WORD_W-bit pseudo-random words from one shared LFSR.
// Latency: req seen in IDLE at t -> grant at t+1 -> rvalid/rdata at t+1+WORD_W; one word per WORD_W+2 cycles.
// Backpressure: none queued; requesters hold req until their rvalid bit, seed_load must be retried while busy.
//
// Ports: clk, nrst (async active-low) | req[NREQ]: level requests | seed_load, seed_in[16]:
//        reseed, accepted only in IDLE | busy: not IDLE | grant[NREQ]: one-hot owner |
//        rdata[WORD_W]: last completed word | rvalid[NREQ]: one-cycle strobe to the owner.
// Optional: define LFSR_RAND_SCHED_STATS_EN to add words_served[16] (words delivered,
//           wraps, cleared by an accepted seed_load).
module lfsr_rand_sched
    import lfsr_pkg::*;
#(
    parameter int              NREQ   = 4,
    parameter int              WORD_W = 16,
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NREQ-1:0]   req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic [NREQ-1:0]   grant,
    output logic [WORD_W-1:0] rdata,
    output logic [NREQ-1:0]   rvalid
`ifdef LFSR_RAND_SCHED_STATS_EN
    ,
    output logic [15:0]       words_served
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SH_W  = (WORD_W > 1) ? WORD_W - 1 : 1;

    lfsr_sched_state_t state;
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   rdata_sh;
    logic [WORD_W-1:0] sh_next;
    logic              sout;
    logic              lfsr_adv;
    logic              lfsr_load;
    logic              shift_last;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;

    assign lfsr_adv   = (state == SHIFT);
    assign lfsr_load  = (state == IDLE) && seed_load;
    assign shift_last = (cnt == CNT_W'(WORD_W - 1));
    assign busy       = (state != IDLE);
    assign rvalid     = (state == DONE) ? grant : '0;

    lfsr_core #(
        .SEED     (SEED)
    ) u_core (
        .clk      (clk),
        .nrst     (nrst),
        .adv      (lfsr_adv),
        .load     (lfsr_load),
        .load_val (seed_in),
        .sout     (sout)
    );

    // First serial bit ends up in the MSB of the returned word.
    // Only WORD_W-1 bits need to be kept between cycles; the newest bit
    // joins them combinationally on the final shift.
    generate
        if (WORD_W > 1) begin : g_sh_wide
            assign sh_next = {rdata_sh, sout};
        end else begin : g_sh_one
            assign sh_next = sout;
        end
    endgenerate

    // Round-robin search: start just after the last winner and wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req[(int'(ptr) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= PTR_W'(NREQ - 1);
            cnt      <= '0;
            rdata_sh <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A seed load owns the cycle; requests wait for the next one.
                    if (!seed_load && win_found) begin
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        ptr   <= win_idx;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rdata_sh <= sh_next[SH_W-1:0];
                    cnt      <= cnt + 1'b1;
                    if (shift_last) begin
                        rdata <= sh_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_RAND_SCHED_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            words_served <= '0;
        end else if (lfsr_load) begin
            words_served <= '0;
        end else if (state == DONE) begin
            words_served <= words_served + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Purpose: self-checking bench for lfsr_rand_sched against a bit-stream / round-robin reference model.
// Latency: checks grant at t+1 and rvalid at t+1+WORD_W relative to the sampling edge.
// Backpressure: requesters hold req until their rvalid bit, then drop it.
module tb_lfsr_rand_sched;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;

    logic              clk;
    logic              nrst;
    logic [NREQ-1:0]   req;
    logic              seed_load;
    logic [15:0]       seed_in;
    logic              busy;
    logic [NREQ-1:0]   grant;
    logic [WORD_W-1:0] rdata;
    logic [NREQ-1:0]   rvalid;
`ifdef LFSR_RAND_SCHED_STATS_EN
    logic [15:0]       words_served;
`endif

    int checks = 0;
    int errors = 0;

    lfsr_rand_sched #(
        .NREQ      (NREQ),
        .WORD_W    (WORD_W),
        .SEED      (16'hA2C1)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .grant     (grant),
        .rdata     (rdata),
        .rvalid    (rvalid)
`ifdef LFSR_RAND_SCHED_STATS_EN
        ,
        .words_served (words_served)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The LFSR is modelled as its output bit stream: the first 16 bits are the
    // seed LSB-first, and every later bit obeys b[n+16] = b[n] ^ b[n+13] ^ b[n+14].
    bit mq[$];
    int mptr;

    function automatic void model_seed(input logic [15:0] s);
        logic [15:0] v;
        v = (s == 16'h0000) ? 16'hA2C1 : s;
        mq.delete();
        for (int i = 0; i < 16; i++) mq.push_back(v[i]);
    endfunction

    function automatic logic [WORD_W-1:0] model_word();
        logic [WORD_W-1:0] w;
        bit b;
        w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            b = mq[0];
            mq.push_back(mq[0] ^ mq[13] ^ mq[14]);
            void'(mq.pop_front());
            w = {w[WORD_W-2:0], b};
        end
        return w;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] r);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Counts negedges until rvalid is seen; n = -1 if it never appears.
    task automatic wait_rvalid(input int limit, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < limit) begin
            @(negedge clk);
            i++;
            if (rvalid != '0) n = i;
        end
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        req       = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        model_seed(16'hA2C1);
        mptr = NREQ - 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0; req = '0; seed_load = 1'b0; seed_in = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (grant !== '0)   begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
        checks++; if (rvalid !== '0)  begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        checks++; if (rdata !== '0)   begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    endtask

    task automatic test_single();
        int n;
        int idx;
        logic [WORD_W-1:0] w;
        do_reset();
        req = 4'b0001;
        idx = model_pick(req);
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", grant); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        wait_rvalid(40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL single_latency got %0d want 16 more cycles", n); end
        checks++; if (rvalid !== 4'(1 << idx)) begin errors++; $display("FAIL single_rvalid got %b want %b", rvalid, 4'(1 << idx)); end
        w = model_word();
        checks++; if (rdata !== w)        begin errors++; $display("FAIL single_word got %h want %h", rdata, w); end
        checks++; if (rdata !== 16'h8345) begin errors++; $display("FAIL single_word_const got %h want 8345", rdata); end
        mptr = idx;
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== '0 || grant !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_after got rv=%b gr=%b busy=%b want 0/0/0", rvalid, grant, busy);
        end
        checks++; if (rdata !== w) begin errors++; $display("FAIL single_hold got %h want %h", rdata, w); end
    endtask

    task automatic test_seed();
        int n;
        int idx;
        logic [WORD_W-1:0] w;
        logic [15:0] seeds [2];
        logic [15:0] consts [2];
        seeds[0] = 16'h0001; consts[0] = 16'h8000;
        seeds[1] = 16'h0000; consts[1] = 16'h8345;
        for (int s = 0; s < 2; s++) begin
            seed_load = 1'b1; seed_in = seeds[s];
            @(negedge clk);
            seed_load = 1'b0;
            model_seed(seeds[s]);
            req = 4'b0100;
            idx = model_pick(req);
            wait_rvalid(40, n);
            checks++; if (n !== 17) begin errors++; $display("FAIL seed_latency[%0d] got %0d want 17", s, n); end
            checks++; if (rvalid !== 4'(1 << idx)) begin errors++; $display("FAIL seed_rvalid[%0d] got %b want %b", s, rvalid, 4'(1 << idx)); end
            w = model_word();
            checks++; if (rdata !== w) begin errors++; $display("FAIL seed_word[%0d] got %h want %h", s, rdata, w); end
            checks++; if (rdata !== consts[s]) begin errors++; $display("FAIL seed_word_const[%0d] got %h want %h", s, rdata, consts[s]); end
            mptr = idx;
            req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int idx;
        logic [WORD_W-1:0] w;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        nrst = 1'b0; seed_load = 1'b0; req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        model_seed(16'hA2C1);
        mptr = NREQ - 1;
        for (int i = 0; i < 5; i++) begin
            idx = model_pick(req);
            wait_rvalid(40, n);
            checks++; if (n !== ((i == 0) ? 17 : 18)) begin
                errors++; $display("FAIL rr_spacing[%0d] got %0d want %0d", i, n, (i == 0) ? 17 : 18);
            end
            checks++; if (rvalid !== 4'(1 << order[i]) || grant !== 4'(1 << order[i])) begin
                errors++; $display("FAIL rr_owner[%0d] got rv=%b gr=%b want %b", i, rvalid, grant, 4'(1 << order[i]));
            end
            w = model_word();
            checks++; if (rdata !== w) begin errors++; $display("FAIL rr_word[%0d] got %h want %h", i, rdata, w); end
            mptr = idx;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_seed_during_shift();
        int n;
        int idx;
        int bad;
        logic [WORD_W-1:0] w;
        req = 4'b0010;
        idx = model_pick(req);
        n = -1;
        bad = 0;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            if (i == 4) begin seed_load = 1'b1; seed_in = 16'($urandom_range(1, 65535)); end
            if (i == 5) seed_load = 1'b0;
            @(negedge clk);
            if (busy !== 1'b1) bad++;
            if (rvalid != '0) n = i;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL shift_busy got %0d low cycles want 0", bad); end
        checks++; if (n !== 17) begin errors++; $display("FAIL shift_latency got %0d want 17", n); end
        checks++; if (rvalid !== 4'(1 << idx)) begin errors++; $display("FAIL shift_rvalid got %b want %b", rvalid, 4'(1 << idx)); end
        w = model_word();
        checks++; if (rdata !== w) begin errors++; $display("FAIL shift_word got %h want %h", rdata, w); end
        mptr = idx;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        int idx;
        int seen;
        logic [WORD_W-1:0] w;
        req = 4'b0001;
        @(negedge clk);               // grant cycle, counter 0
        repeat (7) @(negedge clk);    // counter 7
        #2 nrst = 1'b0;
        req = '0;
        #1;
        checks++; if (grant !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_state got gr=%b busy=%b want 0/0", grant, busy);
        end
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid != '0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_rvalid got %0d strobes want 0", seen); end
        model_seed(16'hA2C1);
        mptr = NREQ - 1;
        req = 4'b0010;
        idx = model_pick(req);
        wait_rvalid(40, n);
        checks++; if (n !== 17) begin errors++; $display("FAIL midreset_latency got %0d want 17", n); end
        w = model_word();
        checks++; if (rdata !== 16'h8345 || rdata !== w) begin
            errors++; $display("FAIL midreset_word got %h want 8345", rdata);
        end
        mptr = idx;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        int idx;
        logic [WORD_W-1:0] w;
        logic [15:0] s;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                seed_load = 1'b1; seed_in = s;
                @(negedge clk);
                seed_load = 1'b0;
                model_seed(s);
            end
            req = 4'($urandom_range(1, 15));
            idx = model_pick(req);
            wait_rvalid(40, n);
            checks++; if (n !== 17) begin errors++; $display("FAIL rand_latency[%0d] got %0d want 17", it, n); end
            checks++; if (rvalid !== 4'(1 << idx) || grant !== 4'(1 << idx)) begin
                errors++; $display("FAIL rand_owner[%0d] req=%b got rv=%b gr=%b want %b", it, req, rvalid, grant, 4'(1 << idx));
            end
            w = model_word();
            checks++; if (rdata !== w) begin errors++; $display("FAIL rand_word[%0d] got %h want %h", it, rdata, w); end
            mptr = idx;
            req = '0;
            @(negedge clk);
        end
    endtask

`ifdef LFSR_RAND_SCHED_STATS_EN
    task automatic test_stats();
        int n;
        do_reset();
        checks++; if (words_served !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d want 0", words_served); end
        for (int i = 0; i < 3; i++) begin
            req = 4'b1000;
            wait_rvalid(40, n);
            req = '0;
            @(negedge clk);
        end
        checks++; if (words_served !== 16'd3) begin errors++; $display("FAIL stats_count got %0d want 3", words_served); end
        seed_load = 1'b1; seed_in = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        checks++; if (words_served !== 16'd0) begin errors++; $display("FAIL stats_clear got %0d want 0", words_served); end
    endtask
`endif

    initial begin
        nrst = 1'b0; req = '0; seed_load = 1'b0; seed_in = '0;
        mptr = NREQ - 1;
        test_reset();
        test_single();
        test_seed();
        test_round_robin();
        test_seed_during_shift();
        test_reset_mid();
        test_random();
`ifdef LFSR_RAND_SCHED_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
